// File: rtl/corriente_disp_pkg.sv
// ---------------------------------------------------------------------------
// corriente_disp_pkg
// Shared definitions for the current-setpoint display driver:
//   - BCD / binary widths
//   - conversion FSM state encoding
//   - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - seg_encode(): BCD nibble -> segment code (non-decimal nibbles blank)
// ---------------------------------------------------------------------------
package corriente_disp_pkg;

  localparam int BCD_W = 16;
  localparam int BIN_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Active-low, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/corriente_display_driver_bin2bcd_step.sv
// ---------------------------------------------------------------------------
// bin2bcd_step
// One combinational iteration of the shift-add-3 (double dabble) algorithm on
// a {bcd[15:0], bin[9:0]} working vector: every BCD nibble >= 5 gets +3, then
// the whole vector shifts left by one bit.
// Ports:
//   vec_i  in  26  working vector before the iteration
//   vec_o  out 26  working vector after add-3 and shift
// ---------------------------------------------------------------------------
module bin2bcd_step
  import corriente_disp_pkg::*;
(
  input  logic [BCD_W+BIN_W-1:0] vec_i,
  output logic [BCD_W+BIN_W-1:0] vec_o
);

  logic [BCD_W+BIN_W-1:0] adj;

  always_comb begin
    adj = vec_i;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (vec_i[BIN_W + 4*i +: 4] >= 4'd5) begin
        adj[BIN_W + 4*i +: 4] = vec_i[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    vec_o = {adj[BCD_W+BIN_W-2:0], 1'b0};
  end

endmodule

// File: rtl/corriente_display_driver.sv
// ---------------------------------------------------------------------------
// corriente_display_driver
// Converts two 10-bit current setpoints to BCD (serial shift-add-3, both
// channels in parallel) and scans the 8 resulting digits onto a common-anode
// 7-segment display. Digits 7..4 show val_a, digits 3..0 show val_b.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   : leading zeros above the units digit of each 4-digit group
//               are blanked
//   undefined : all digits always shown
//
// Parameters:
//   REFRESH_BITS  scan counter width (top 3 bits select the digit), >= 3
//   CONV_STEPS    shift-add-3 iterations, equal to the input width (10)
// Ports:
//   clk    in   1   system clock
//   reset  in   1   asynchronous active-high reset
//   val_a  in   10  adjustable setpoint, binary
//   val_b  in   10  preset setpoint, binary
//   busy   out  1   conversion in progress
//   bcd_a  out  16  BCD of val_a ([15:12] thousands .. [3:0] units)
//   bcd_b  out  16  BCD of val_b
//   an     out  8   digit enables, active-low, an[0] = rightmost
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1   decimal point, active-low, always off
//
// Handshake: none. The block watches val_a/val_b continuously; busy is a
// status flag only. bcd_a/bcd_b change only on the edge busy falls.
// FSM state is visible as state_q for debug.
// ---------------------------------------------------------------------------
module corriente_display_driver
  import corriente_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int CONV_STEPS   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_W-1:0]        val_a,
  input  logic [BIN_W-1:0]        val_b,
  output logic                    busy,
  output logic [BCD_W-1:0]        bcd_a,
  output logic [BCD_W-1:0]        bcd_b,
  output logic [7:0]              an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int WORK_W = BCD_W + BIN_W;

  state_e                  state_q, state_d;
  logic [3:0]              step_q, step_d;
  logic                    busy_q, busy_d;
  logic [BIN_W-1:0]        shadow_a_q, shadow_a_d;
  logic [BIN_W-1:0]        shadow_b_q, shadow_b_d;
  logic [WORK_W-1:0]       work_a_q, work_a_d, work_a_nx;
  logic [WORK_W-1:0]       work_b_q, work_b_d, work_b_nx;
  logic [BCD_W-1:0]        bcd_a_q, bcd_a_d;
  logic [BCD_W-1:0]        bcd_b_q, bcd_b_d;
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [2:0]              idx;
  logic [BCD_W-1:0]        grp;
  logic [3:0]              nib;
  logic                    blank;

  bin2bcd_step u_step_a (.vec_i(work_a_q), .vec_o(work_a_nx));
  bin2bcd_step u_step_b (.vec_i(work_b_q), .vec_o(work_b_nx));

  // Conversion FSM next-state
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    busy_d     = busy_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    work_a_d   = work_a_q;
    work_b_d   = work_b_q;
    bcd_a_d    = bcd_a_q;
    bcd_b_d    = bcd_b_q;
    case (state_q)
      IDLE: begin
        // Both channels are recaptured together so one pass covers both.
        if ((val_a != shadow_a_q) || (val_b != shadow_b_q)) begin
          shadow_a_d = val_a;
          shadow_b_d = val_b;
          work_a_d   = {{BCD_W{1'b0}}, val_a};
          work_b_d   = {{BCD_W{1'b0}}, val_b};
          step_d     = 4'd0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        work_a_d = work_a_nx;
        work_b_d = work_b_nx;
        step_d   = step_q + 4'd1;
        if (step_q == 4'(CONV_STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_a_d = work_a_q[BIN_W +: BCD_W];
        bcd_b_d = work_b_q[BIN_W +: BCD_W];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Scan: digit select from the counter MSBs, outputs registered one cycle
  // behind the counter.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx   = cnt_q[REFRESH_BITS-1 -: 3];
    grp   = idx[2] ? bcd_a_q : bcd_b_q;
    nib   = grp[4*idx[1:0] +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more-significant digit of its
    // group are zero; the units digit is never blanked.
    case (idx[1:0])
      2'd3:    blank = (grp[15:12] == 4'd0);
      2'd2:    blank = (grp[15:8]  == 8'd0);
      2'd1:    blank = (grp[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    an_d  = ~(8'd1 << idx);
    seg_d = blank ? SEG_BLANK : seg_encode(nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= 4'd0;
      busy_q     <= 1'b0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      work_a_q   <= '0;
      work_b_q   <= '0;
      bcd_a_q    <= '0;
      bcd_b_q    <= '0;
      cnt_q      <= '0;
      an_q       <= 8'hFF;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      work_a_q   <= work_a_d;
      work_b_q   <= work_b_d;
      bcd_a_q    <= bcd_a_d;
      bcd_b_q    <= bcd_b_d;
      cnt_q      <= cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy  = busy_q;
  assign bcd_a = bcd_a_q;
  assign bcd_b = bcd_b_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;

endmodule

// File: tb/tb_corriente_display_driver.sv
// ---------------------------------------------------------------------------
// tb_corriente_display_driver
// Directed bench for corriente_display_driver (REFRESH_BITS=4). Expected
// values are hand-computed constants. Honors LEADING_ZERO_BLANK_EN for the
// scan expectations.
// ---------------------------------------------------------------------------
module tb_corriente_display_driver;

  logic        clk;
  logic        reset;
  logic [9:0]  val_a;
  logic [9:0]  val_b;
  logic        busy;
  logic [15:0] bcd_a;
  logic [15:0] bcd_b;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests_run;
  int tests_failed;

  corriente_display_driver #(.REFRESH_BITS(4), .CONV_STEPS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .val_a (val_a),
    .val_b (val_b),
    .busy  (busy),
    .bcd_a (bcd_a),
    .bcd_b (bcd_b),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for busy to rise, then counts the cycles it stays high.
  // Returns 0 when busy never rises.
  task automatic run_conv(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (!busy && guard < 5) begin
      step();
      guard++;
    end
    if (busy) begin
      n = 1;
      guard = 0;
      while (busy && guard < 40) begin
        step();
        if (busy) n++;
        guard++;
      end
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 40) begin
      step();
      guard++;
    end
    check_eq("busy_fall_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Counts busy-high samples over a quiet window (expect no conversion).
  task automatic check_quiet(input string tag);
    int hi;
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (busy) hi++;
    end
    check_eq(tag, hi, 0);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int n;
    int guard;
    int exp_dig [0:7];
    bit exp_blank [0:7];
    logic [7:0] exp_an;
    logic [6:0] exp_seg;

    tests_run    = 0;
    tests_failed = 0;

    // 1. reset held with nonzero inputs
    reset = 1'b1;
    val_a = 10'd500;
    val_b = 10'd30;
    step(); step(); step();
    check_eq("rst_an",    an,    8'hFF);
    check_eq("rst_seg",   seg,   7'h7F);
    check_eq("rst_bcd_a", bcd_a, 16'h0000);
    check_eq("rst_bcd_b", bcd_b, 16'h0000);
    check_eq("rst_busy",  busy,  1'b0);
    check_eq("rst_dp",    dp,    1'b1);

    // 2. release -> first conversion
    reset = 1'b0;
    run_conv(n);
    check_eq("conv1_cycles", n, 11);
    check_eq("conv1_bcd_a", bcd_a, 16'h0500);
    check_eq("conv1_bcd_b", bcd_b, 16'h0030);

    // 3. val_a 500 -> 1000
    val_a = 10'd1000;
    run_conv(n);
    check_eq("conv2_cycles", n, 11);
    check_eq("conv2_bcd_a", bcd_a, 16'h1000);
    check_eq("conv2_bcd_b", bcd_b, 16'h0030);

    // 4a. val_b glitch 30->200->30 mid-conversion: no second pass
    val_a = 10'd500;
    step();
    check_eq("glitch_busy_rise", busy, 1'b1);
    for (int i = 0; i < 4; i++) step();
    val_b = 10'd200;
    step(); step();
    val_b = 10'd30;
    wait_idle();
    check_eq("glitch_bcd_a", bcd_a, 16'h0500);
    check_eq("glitch_bcd_b", bcd_b, 16'h0030);
    check_quiet("glitch_no_reconv");

    // 4b. val_b change held across a conversion: captured value first, then reconvert
    val_a = 10'd600;
    step();
    for (int i = 0; i < 3; i++) step();
    val_b = 10'd200;
    wait_idle();
    check_eq("held_first_bcd_a", bcd_a, 16'h0600);
    check_eq("held_first_bcd_b", bcd_b, 16'h0030);
    run_conv(n);
    check_eq("held_second_cycles", n, 11);
    check_eq("held_second_bcd_a", bcd_a, 16'h0600);
    check_eq("held_second_bcd_b", bcd_b, 16'h0200);

    // Boundary values, both channels changing together
    val_a = 10'd1023;
    val_b = 10'd0;
    run_conv(n);
    check_eq("max_cycles", n, 11);
    check_eq("max_bcd_a", bcd_a, 16'h1023);
    check_eq("zero_bcd_b", bcd_b, 16'h0000);
    check_quiet("both_single_pass");

    val_a = 10'd999;
    val_b = 10'd1;
    run_conv(n);
    check_eq("v999_bcd_a", bcd_a, 16'h0999);
    check_eq("v1_bcd_b",   bcd_b, 16'h0001);

    val_a = 10'd500;
    val_b = 10'd30;
    run_conv(n);
    check_eq("restore_cycles", n, 11);
    check_eq("restore_bcd_a", bcd_a, 16'h0500);
    check_eq("restore_bcd_b", bcd_b, 16'h0030);

    // 5. scan with bcd_a=0500, bcd_b=0030
    exp_dig = '{0, 3, 0, 0, 0, 0, 5, 0};
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_blank = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    guard = 0;
    while (an != 8'h7F && guard < 40) begin step(); guard++; end
    guard = 0;
    while (an != 8'hFE && guard < 4) begin step(); guard++; end
    check_eq("scan_align", an, 8'hFE);
    for (int p = 0; p < 16; p++) begin
      exp_an  = ~(8'd1 << (p / 2));
      exp_seg = exp_blank[p/2] ? 7'h7F : seg_of(exp_dig[p/2]);
      check_eq($sformatf("scan_an_p%0d", p),  an,  exp_an);
      check_eq($sformatf("scan_seg_p%0d", p), seg, exp_seg);
      check_eq("scan_dp", dp, 1'b1);
      step();
    end

    // 6. reset pulse during CONV step 5
    val_a = 10'd700;
    step();
    check_eq("rst6_busy_rise", busy, 1'b1);
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst6_busy",  busy,  1'b0);
    check_eq("rst6_bcd_a", bcd_a, 16'h0000);
    check_eq("rst6_bcd_b", bcd_b, 16'h0000);
    check_eq("rst6_an",    an,    8'hFF);
    check_eq("rst6_seg",   seg,   7'h7F);
    step();
    reset = 1'b0;
    run_conv(n);
    check_eq("rst6_cycles", n, 11);
    check_eq("rst6_bcd_a_after", bcd_a, 16'h0700);
    check_eq("rst6_bcd_b_after", bcd_b, 16'h0030);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
